logica_miscare_fsm: RTL and testbench



---
 rtl/logica_miscare_fsm.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_logica_miscare_fsm.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/logica_miscare_fsm.sv
// logica_miscare_fsm
// Registered steering controller for the line-follower car.
// Line sensors are synchronised, then a state machine chooses motor
// directions and duty factors. A debounced finish-line detector counts
// laps and stops the car once the lap target of the latched circuit is met.
//
// Optional build macro: LOGICA_MISCARE_SOFT_START_EN
//   When defined, a ramp limits every duty output after a start from
//   IDLE, LOST or DONE, rising by DC_STEP per cycle up to DC_MAX.
//
// Ports:
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   senzori             line sensors (1 = black), bit 0 rightmost
//   circuit             00 endurance, 01 circuit 1, 10 circuit 2, 11 reserved
//   start               run request, level sampled
//   directie_driverA/B  10 forward, 01 reverse, 00 stop (A right, B left)
//   factor_dc_driverA/B duty compare values
//   semnal_dreapta/stanga  indicators (outer sensors, registered)
//   stop                brake light
//   count_ture          laps completed, saturating
//   gata                lap target reached
//
// state   | meaning
// IDLE    | waiting for start, motors off
// RUN     | centre sensor on the line, straight or correcting
// RECOVER | centre sensor lost, turning back towards the remembered side
// LOST    | recovery timed out, motors off until start
// DONE    | lap target reached, motors off until start

module logica_miscare_fsm #(
    parameter int NUM_SENZORI     = 5,
    parameter int DC_WIDTH        = 12,
    parameter int DC_MAX          = 4095,
    parameter int DC_TURN         = 2048,
    parameter int DEBOUNCE        = 4,
    parameter int TURE_CIRCUIT1   = 1,
    parameter int TURE_CIRCUIT2   = 10,
    parameter int RECOVER_TIMEOUT = 1000,
    parameter int DC_STEP         = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SENZORI-1:0] senzori,
    input  logic [1:0]             circuit,
    input  logic                   start,
    output logic [1:0]             directie_driverA,
    output logic [1:0]             directie_driverB,
    output logic [DC_WIDTH-1:0]    factor_dc_driverA,
    output logic [DC_WIDTH-1:0]    factor_dc_driverB,
    output logic                   semnal_dreapta,
    output logic                   semnal_stanga,
    output logic                   stop,
    output logic [7:0]             count_ture,
    output logic                   gata
);

    localparam int C  = (NUM_SENZORI - 1) / 2;
    localparam int TW = $clog2(RECOVER_TIMEOUT + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);

    localparam logic [DC_WIDTH-1:0] DUTY_MAX  = DC_WIDTH'(DC_MAX);
    localparam logic [DC_WIDTH-1:0] DUTY_TURN = DC_WIDTH'(DC_TURN);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        RECOVER = 3'd2,
        LOST    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [NUM_SENZORI-1:0] sync1, s;
    logic [1:0]             circ_r, circ_d;
    logic                   dreapta_q, dreapta_d;
    logic                   stanga_q, stanga_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [DW-1:0]          deb_q, deb_d;
    logic                   fin_q, fin_d;
    logic                   lap_rise, lap_inc, target_hit;
    logic [7:0]             cnt_d;
    logic                   gata_d;

    logic [1:0]             dir_a_d, dir_b_d;
    logic [DC_WIDTH-1:0]    duty_a_d, duty_b_d;
    logic [DC_WIDTH-1:0]    duty_a_o, duty_b_o;
    logic                   stop_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= senzori;
            s     <= sync1;
        end
    end

    always_comb begin
        state_d    = state_q;
        circ_d     = circ_r;
        dreapta_d  = dreapta_q;
        stanga_d   = stanga_q;
        tmo_d      = tmo_q;
        deb_d      = deb_q;
        fin_d      = fin_q;
        cnt_d      = count_ture;
        gata_d     = gata;
        lap_rise   = 1'b0;
        lap_inc    = 1'b0;
        target_hit = 1'b0;

        // Finish-line debounce: the same counter measures the hold time for
        // acceptance and the clear time for release.
        if (!fin_q) begin
            if (&s) begin
                if (deb_q == DW'(DEBOUNCE - 1)) begin
                    fin_d    = 1'b1;
                    deb_d    = '0;
                    lap_rise = 1'b1;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end else begin
                deb_d = '0;
            end
        end else begin
            if (!(&s)) begin
                if (deb_q == DW'(DEBOUNCE - 1)) begin
                    fin_d = 1'b0;
                    deb_d = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end else begin
                deb_d = '0;
            end
        end

        lap_inc = lap_rise && (state_q == RUN || state_q == RECOVER);
        if (lap_inc && count_ture != 8'hFF)
            cnt_d = count_ture + 8'd1;
        target_hit = lap_inc &&
                     ((circ_r == 2'b01 && cnt_d == 8'(TURE_CIRCUIT1)) ||
                      (circ_r == 2'b10 && cnt_d == 8'(TURE_CIRCUIT2)));

        case (state_q)
            IDLE, DONE: begin
                if (start && circuit != 2'b11) begin
                    circ_d    = circuit;
                    cnt_d     = '0;
                    gata_d    = 1'b0;
                    dreapta_d = 1'b0;
                    stanga_d  = 1'b0;
                    tmo_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (s[C]) begin
                    if (s[C-1] == s[C+1]) begin
                        dreapta_d = 1'b0;
                        stanga_d  = 1'b0;
                    end else if (s[C-1]) begin
                        dreapta_d = 1'b1;
                        stanga_d  = 1'b0;
                    end else begin
                        dreapta_d = 1'b0;
                        stanga_d  = 1'b1;
                    end
                end else begin
                    // Only a one-sided inner reading changes the memory here;
                    // both inner sensors dark must keep the last known side.
                    if (s[C-1] && !s[C+1]) begin
                        dreapta_d = 1'b1;
                        stanga_d  = 1'b0;
                    end else if (s[C+1] && !s[C-1]) begin
                        dreapta_d = 1'b0;
                        stanga_d  = 1'b1;
                    end
                    tmo_d   = '0;
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                if (s[C-1] && !s[C+1]) begin
                    dreapta_d = 1'b1;
                    stanga_d  = 1'b0;
                end else if (s[C+1] && !s[C-1]) begin
                    dreapta_d = 1'b0;
                    stanga_d  = 1'b1;
                end
                if (s[C]) begin
                    tmo_d   = '0;
                    state_d = RUN;
                end else if (tmo_q == TW'(RECOVER_TIMEOUT - 1)) begin
                    tmo_d   = '0;
                    state_d = LOST;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            LOST: begin
                if (start) begin
                    dreapta_d = 1'b0;
                    stanga_d  = 1'b0;
                    tmo_d     = '0;
                    state_d   = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (target_hit) begin
            state_d = DONE;
            gata_d  = 1'b1;
        end
    end

    // Outputs are derived from the state being entered so that the registered
    // outputs match the state on the same edge.
    always_comb begin
        dir_a_d  = 2'b00;
        dir_b_d  = 2'b00;
        duty_a_d = '0;
        duty_b_d = '0;
        stop_d   = 1'b1;
        case (state_d)
            RUN: begin
                dir_a_d = 2'b10;
                dir_b_d = 2'b10;
                stop_d  = 1'b0;
                if (s[C-1] == s[C+1]) begin
                    duty_a_d = DUTY_MAX;
                    duty_b_d = DUTY_MAX;
                end else if (s[C-1]) begin
                    duty_a_d = DUTY_TURN;
                    duty_b_d = DUTY_MAX;
                end else begin
                    duty_a_d = DUTY_MAX;
                    duty_b_d = DUTY_TURN;
                end
            end
            RECOVER: begin
                duty_a_d = DUTY_TURN;
                duty_b_d = DUTY_TURN;
                if (dreapta_d) begin
                    dir_a_d = 2'b01;
                    dir_b_d = 2'b10;
                end else if (stanga_d) begin
                    dir_a_d = 2'b10;
                    dir_b_d = 2'b01;
                end else begin
                    dir_a_d = 2'b10;
                    dir_b_d = 2'b10;
                end
            end
            default: ;
        endcase
    end

`ifdef LOGICA_MISCARE_SOFT_START_EN
    logic [DC_WIDTH-1:0] ramp_q, ramp_d;
    logic [DC_WIDTH:0]   ramp_sum;
    logic [DC_WIDTH:0]   ramp_first;
    logic                restart;

    always_comb begin
        restart    = (state_d == RUN) &&
                     (state_q == IDLE || state_q == LOST || state_q == DONE);
        ramp_sum   = {1'b0, ramp_q} + (DC_WIDTH + 1)'(DC_STEP);
        ramp_first = (DC_WIDTH + 1)'(DC_STEP);
        ramp_d     = '0;
        // The ramp starts one step up so the first running cycle already moves.
        if (restart)
            ramp_d = (ramp_first > {1'b0, DUTY_MAX}) ? DUTY_MAX : ramp_first[DC_WIDTH-1:0];
        else if (state_d == RUN || state_d == RECOVER)
            ramp_d = (ramp_sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : ramp_sum[DC_WIDTH-1:0];
        duty_a_o = (duty_a_d < ramp_d) ? duty_a_d : ramp_d;
        duty_b_o = (duty_b_d < ramp_d) ? duty_b_d : ramp_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ramp_q <= '0;
        else        ramp_q <= ramp_d;
    end
`else
    always_comb begin
        duty_a_o = duty_a_d;
        duty_b_o = duty_b_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            circ_r            <= 2'b00;
            dreapta_q         <= 1'b0;
            stanga_q          <= 1'b0;
            tmo_q             <= '0;
            deb_q             <= '0;
            fin_q             <= 1'b0;
            count_ture        <= '0;
            gata              <= 1'b0;
            directie_driverA  <= 2'b00;
            directie_driverB  <= 2'b00;
            factor_dc_driverA <= '0;
            factor_dc_driverB <= '0;
            stop              <= 1'b1;
            semnal_dreapta    <= 1'b0;
            semnal_stanga     <= 1'b0;
        end else begin
            state_q           <= state_d;
            circ_r            <= circ_d;
            dreapta_q         <= dreapta_d;
            stanga_q          <= stanga_d;
            tmo_q             <= tmo_d;
            deb_q             <= deb_d;
            fin_q             <= fin_d;
            count_ture        <= cnt_d;
            gata              <= gata_d;
            directie_driverA  <= dir_a_d;
            directie_driverB  <= dir_b_d;
            factor_dc_driverA <= duty_a_o;
            factor_dc_driverB <= duty_b_o;
            stop              <= stop_d;
            semnal_dreapta    <= s[0];
            semnal_stanga     <= s[NUM_SENZORI-1];
        end
    end

endmodule

// File: tb/tb_logica_miscare_fsm.sv
// Directed testbench for logica_miscare_fsm (default parameters).

module tb_logica_miscare_fsm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  senzori = 5'b00000;
   logic [1:0]  circuit = 2'b00;
   logic        start = 1'b0;
   logic [1:0]  directie_driverA, directie_driverB;
   logic [11:0] factor_dc_driverA, factor_dc_driverB;
   logic        semnal_dreapta, semnal_stanga, stop, gata;
   logic [7:0]  count_ture;

   int checks = 0;
   int errors = 0;

   logica_miscare_fsm dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .senzori           (senzori),
      .circuit           (circuit),
      .start             (start),
      .directie_driverA  (directie_driverA),
      .directie_driverB  (directie_driverB),
      .factor_dc_driverA (factor_dc_driverA),
      .factor_dc_driverB (factor_dc_driverB),
      .semnal_dreapta    (semnal_dreapta),
      .semnal_stanga     (semnal_stanga),
      .stop              (stop),
      .count_ture        (count_ture),
      .gata              (gata)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      #23;
      chk("rst_dirA", directie_driverA, 2'b00);
      chk("rst_dirB", directie_driverB, 2'b00);
      chk("rst_dutyA", factor_dc_driverA, 12'd0);
      chk("rst_dutyB", factor_dc_driverB, 12'd0);
      chk("rst_stop", stop, 1'b1);
      chk("rst_count", count_ture, 8'd0);
      chk("rst_gata", gata, 1'b0);
      rst_n = 1'b1;
      tick(1);

      circuit = 2'b11; start = 1'b1;
      tick(2);
      chk("c11_dirA", directie_driverA, 2'b00);
      chk("c11_stop", stop, 1'b1);
      start = 1'b0;
      tick(1);

      circuit = 2'b01; senzori = 5'b00100; start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(2);
      chk("run_dirA", directie_driverA, 2'b10);
      chk("run_dirB", directie_driverB, 2'b10);
      chk("run_dutyA", factor_dc_driverA, 12'd4095);
      chk("run_dutyB", factor_dc_driverB, 12'd4095);
      chk("run_stop", stop, 1'b0);
      chk("run_count", count_ture, 8'd0);

      senzori = 5'b00110;
      tick(3);
      chk("corr_dutyA", factor_dc_driverA, 12'd2048);
      chk("corr_dutyB", factor_dc_driverB, 12'd4095);
      chk("corr_dirA", directie_driverA, 2'b10);

      senzori = 5'b00000;
      tick(3);
      chk("rec_dirA", directie_driverA, 2'b01);
      chk("rec_dirB", directie_driverB, 2'b10);
      chk("rec_dutyA", factor_dc_driverA, 12'd2048);
      chk("rec_stop", stop, 1'b1);

      senzori = 5'b00100;
      tick(3);
      chk("back_dutyA", factor_dc_driverA, 12'd4095);
      chk("back_dutyB", factor_dc_driverB, 12'd4095);
      chk("back_stop", stop, 1'b0);

      senzori = 5'b00000;
      tick(3);
      tick(1100);
      chk("lost_dirA", directie_driverA, 2'b00);
      chk("lost_dirB", directie_driverB, 2'b00);
      chk("lost_dutyA", factor_dc_driverA, 12'd0);
      chk("lost_stop", stop, 1'b1);
      senzori = 5'b00100;
      tick(3);
      chk("lost_hold_dirA", directie_driverA, 2'b00);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("relost_dirA", directie_driverA, 2'b10);
      chk("relost_dutyA", factor_dc_driverA, 12'd4095);
      chk("relost_count", count_ture, 8'd0);

      senzori = 5'b11111;
      tick(3);
      senzori = 5'b00100;
      tick(6);
      chk("short_fin_count", count_ture, 8'd0);
      chk("short_fin_gata", gata, 1'b0);

      senzori = 5'b11111;
      tick(4);
      senzori = 5'b00100;
      tick(1);
      chk("pre_lap_count", count_ture, 8'd0);
      chk("pre_lap_stop", stop, 1'b0);
      tick(1);
      chk("lap1_count", count_ture, 8'd1);
      chk("lap1_gata", gata, 1'b1);
      chk("lap1_dirA", directie_driverA, 2'b00);
      chk("lap1_dutyB", factor_dc_driverB, 12'd0);
      chk("lap1_stop", stop, 1'b1);
      tick(8);

      circuit = 2'b10; start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("c2_count0", count_ture, 8'd0);
      chk("c2_gata0", gata, 1'b0);
      chk("c2_stop0", stop, 1'b0);
      for (int i = 0; i < 10; i++) begin
         senzori = 5'b11111;
         tick(5);
         senzori = 5'b00100;
         tick(8);
         chk("c2_lap_count", count_ture, 8'(i + 1));
      end
      chk("c2_gata", gata, 1'b1);
      chk("c2_dirA", directie_driverA, 2'b00);
      senzori = 5'b11111;
      tick(5);
      senzori = 5'b00100;
      tick(8);
      chk("c2_extra_count", count_ture, 8'd10);

      #3 rst_n = 1'b0;
      #1;
      chk("arst_count", count_ture, 8'd0);
      chk("arst_gata", gata, 1'b0);
      chk("arst_stop", stop, 1'b1);
      rst_n = 1'b1;
      tick(1);

      circuit = 2'b01; start = 1'b1;
      tick(1);
      start = 1'b0;
`ifdef LOGICA_MISCARE_SOFT_START_EN
      chk("ramp1", factor_dc_driverA, 12'd64);
      tick(1);
      chk("ramp2", factor_dc_driverA, 12'd128);
      tick(1);
      chk("ramp3", factor_dc_driverA, 12'd192);
      tick(70);
      chk("ramp_sat", factor_dc_driverA, 12'd4095);
`else
      chk("nostep_duty", factor_dc_driverA, 12'd4095);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
